// File: rtl/des3_cbc_sequencer.sv
// Chaining sequencer in front of the 3DES core: CBC when DES3_CBC_EN is defined, ECB otherwise.
// Block latency is core latency + 2; in_ready is low while a block is in flight or the core's valid level is still high.
module des3_cbc_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             decrypt,
  input  logic             iv_load,
  input  logic [63:0]      iv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             core_start,
  output logic [63:0]      core_din,
  output logic             core_decrypt,
  input  logic [63:0]      core_dout,
  input  logic             core_valid,
  output logic [CNT_W-1:0] blk_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        complete;
  logic        deliver;
  logic        load;
  logic [63:0] din_nxt;
  logic [63:0] dout_nxt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = BUSY;
      BUSY:    if (core_valid) state_nxt = OUT;
      OUT:     if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Holding in_ready low until core_valid drops keeps a stale level from completing the next block.
  always_comb begin
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE:    in_ready   = ~core_valid & ~iv_load;
      BUSY:    core_start = 1'b1;
      OUT:     out_valid  = 1'b1;
      default: in_ready   = 1'b0;
    endcase
  end

  assign accept   = in_valid & in_ready;
  assign complete = (state == BUSY) & core_valid;
  assign deliver  = out_valid & out_ready;
  assign load     = (state == IDLE) & iv_load;

`ifdef DES3_CBC_EN
  logic [63:0] chain;
  logic [63:0] hold;

  // core_decrypt doubles as the latched mode of the block in flight.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      chain <= '0;
      hold  <= '0;
    end else begin
      if (load) begin
        chain <= iv;
      end else if (complete) begin
        chain <= core_decrypt ? hold : core_dout;
      end
      if (accept) begin
        hold <= in_data;
      end
    end
  end

  assign din_nxt  = decrypt ? in_data : (in_data ^ chain);
  assign dout_nxt = core_decrypt ? (core_dout ^ chain) : core_dout;
`else
  logic unused_iv;
  assign unused_iv = ^iv;
  assign din_nxt   = in_data;
  assign dout_nxt  = core_dout;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      core_din     <= '0;
      core_decrypt <= 1'b0;
      out_data     <= '0;
      blk_count    <= '0;
    end else begin
      if (accept) begin
        core_din     <= din_nxt;
        core_decrypt <= decrypt;
      end
      if (complete) begin
        out_data <= dout_nxt;
      end
      if (load) begin
        blk_count <= '0;
      end else if (deliver) begin
        blk_count <= blk_count + CNT_W'(1);
      end
    end
  end

endmodule
